// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU and its word-level front end.
package alu_pkg;

    // Operand/result width of a word and the number of serial cycles per word.
    localparam int ALU_WIDTH = 8;

    // ALU opcodes as driven onto the serial ALU's opcode input.
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_EQ   = 3'd5;
    localparam logic [2:0] OP_GT   = 3'd6;
    localparam logic [2:0] OP_ZERO = 3'd7;

    // Word front-end sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLAG,
        RESULT
    } state_e;

endpackage

// File: rtl/serial_shift.sv
// WIDTH-bit right-shift register with parallel load, shift enable and serial
// in (enters at the MSB) / serial out (bit 0). Load has priority over shift.
module serial_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next contents: load a new word, shift one place toward bit 0, or hold.
    always_comb begin
        // NOTE: default assignment first so every path drives data_d and no latch is inferred.
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {ser_i, data_q[WIDTH-1:1]};
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so it is not in the sensitivity list.
        if (!rst_n) begin
            // NOTE: non-blocking assignment so all flops update together at the edge.
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign ser_o  = data_q[0];
    assign data_o = data_q;

endmodule

// File: rtl/alu_word_io.sv
// Word-level front end for the bit-serial ALU: accepts parallel operands,
// streams them LSB-first to the ALU, collects the serial result and the end
// of word flag, and offers them as a parallel result. It also owns the ALU
// reset (held low outside a word) and the opcode hold.
module alu_word_io
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [2:0]       op_in,
    output logic             alu_rst_n,
    output logic [2:0]       alu_op,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_y,
    input  logic             alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             c_out
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       op_q,    op_d;
    logic [WIDTH-1:0] y_q,     y_d;
    logic             c_q,     c_d;

    logic             accept;
    logic             shift_en;
    logic             a_bit;
    logic             b_bit;
    logic [WIDTH-1:0] ycap;

    // Parallel views of the operand registers and the serial tap of the
    // capture register are not needed here.
    logic [WIDTH-1:0] a_word_unused;
    logic [WIDTH-1:0] b_word_unused;
    logic             y_ser_unused;

    assign accept   = in_valid && in_ready;
    assign shift_en = (state_q == SHIFT);

    // Operand A: loaded at acceptance, emptied toward the ALU one bit per SHIFT cycle.
    serial_shift #(.WIDTH(WIDTH)) u_shift_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (a_in),
        .shift_i     (shift_en),
        .ser_i       (1'b0),
        .ser_o       (a_bit),
        .data_o      (a_word_unused)
    );

    // Operand B: same as A.
    serial_shift #(.WIDTH(WIDTH)) u_shift_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i (b_in),
        .shift_i     (shift_en),
        .ser_i       (1'b0),
        .ser_o       (b_bit),
        .data_o      (b_word_unused)
    );

    // Result capture: alu_y enters at the MSB, so after WIDTH shifts bit i
    // holds the result for operand bit i.
    serial_shift #(.WIDTH(WIDTH)) u_shift_y (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (accept),
        .load_data_i ('0),
        .shift_i     (shift_en),
        .ser_i       (alu_y),
        .ser_o       (y_ser_unused),
        .data_o      (ycap)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: one word is IDLE(accept) -> WIDTH x SHIFT -> FLAG -> RESULT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)            state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST_BIT) state_d = FLAG;
            FLAG:                           state_d = RESULT;
            RESULT:  if (out_ready)         state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // FSM outputs: the ALU is held in reset outside SHIFT/FLAG so it starts
    // every word from a cleared carry/flag.
    always_comb begin
        in_ready  = (state_q == IDLE) && rst_n;
        out_valid = (state_q == RESULT);
        alu_rst_n = (state_q == SHIFT) || (state_q == FLAG);
        alu_a     = shift_en ? a_bit : 1'b0;
        alu_b     = shift_en ? b_bit : 1'b0;
    end

    // Datapath next state: opcode hold, bit counter and end-of-word result capture.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        y_d   = y_q;
        c_d   = c_q;
        if (accept) begin
            cnt_d = '0;
            op_d  = op_in;
        end
        if (state_q == SHIFT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (state_q == FLAG) begin
            y_d = ycap;
            c_d = alu_c;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            op_q  <= '0;
            y_q   <= '0;
            c_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            y_q   <= y_d;
            c_q   <= c_d;
        end
    end

    assign alu_op = op_q;
    assign y_out  = y_q;
    assign c_out  = c_q;

endmodule

// File: tb/tb_alu_word_io.sv
// Bench for alu_word_io: a behavioural serial ALU stands in for the real
// alu instance; a word-level arithmetic model predicts each result into a
// scoreboard that an independent monitor drains.
module tb_alu_word_io;
    import alu_pkg::*;

    localparam int W = ALU_WIDTH;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [2:0]   op_in;
    logic         alu_rst_n;
    logic [2:0]   alu_op;
    logic         alu_a;
    logic         alu_b;
    logic         alu_y;
    logic         alu_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y_out;
    logic         c_out;

    logic man_ready = 1'b1;
    logic rnd_ready = 1'b1;
    logic rand_bp   = 1'b0;
    assign out_ready = rand_bp ? rnd_ready : man_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;

    logic [W:0] exp_q[$];
    int         acc_q[$];

    alu_word_io #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .alu_rst_n (alu_rst_n),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_c     (alu_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) rnd_ready = ($urandom_range(0, 2) != 0);

    // ---------------- behavioural serial ALU (stand-in for alu) ----------------
    logic alu_fl    = 1'b0;
    logic alu_first = 1'b1;
    logic alu_s;
    logic alu_nf;

    function automatic logic init_flag(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_OR) || (op == OP_EQ) || (op == OP_ZERO);
    endfunction

    always_comb begin
        alu_s  = alu_first ? init_flag(alu_op) : alu_fl;
        alu_y  = 1'b0;
        alu_nf = alu_s;
        case (alu_op)
            OP_ADD:  begin alu_y = alu_a ^ alu_b ^ alu_s;  alu_nf = (alu_a & alu_b) | (alu_s & (alu_a ^ alu_b)); end
            OP_SUB:  begin alu_y = alu_a ^ ~alu_b ^ alu_s; alu_nf = (alu_a & ~alu_b) | (alu_s & ~(alu_a ^ alu_b)); end
            OP_OR:   begin alu_y = alu_a | alu_b;          alu_nf = alu_s & (alu_a | alu_b); end
            OP_AND:  begin alu_y = alu_a & alu_b;          alu_nf = alu_s | (alu_a & alu_b); end
            OP_XOR:  begin alu_y = alu_a ^ alu_b;          alu_nf = alu_s ^ alu_a ^ alu_b; end
            OP_EQ:   begin alu_y = alu_a;                  alu_nf = alu_s & ~(alu_a ^ alu_b); end
            OP_GT:   begin alu_y = alu_a;                  alu_nf = (alu_a & ~alu_b) | (alu_s & ~(alu_a ^ alu_b)); end
            default: begin alu_y = 1'b0;                   alu_nf = 1'b1; end
        endcase
        alu_c = (alu_op == OP_ZERO) ? 1'b1 : alu_s;
    end

    always @(posedge clk) begin
        if (!alu_rst_n) begin
            alu_first <= 1'b1;
        end else begin
            alu_first <= 1'b0;
            alu_fl    <= alu_nf;
        end
    end

    // ---------------- word-level reference model: {c, y} ----------------
    function automatic logic [W:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] op);
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   s;
        case (op)
            OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; y = s[W-1:0]; c = s[W]; end
            OP_SUB:  begin y = a - b; c = (a >= b); end
            OP_OR:   begin y = a | b; c = &y; end
            OP_AND:  begin y = a & b; c = |y; end
            OP_XOR:  begin y = a ^ b; c = ^y; end
            OP_EQ:   begin y = a;     c = (a == b); end
            OP_GT:   begin y = a;     c = (a > b); end
            default: begin y = '0;    c = 1'b1; end
        endcase
        return {c, y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        exp_q.push_back(ref_model(a, b, op));
        acc_q.push_back(cyc);
        last_acc = cyc;
    endtask

    // Present a request and hold it until accepted; returns in the first SHIFT cycle.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bit done = 1'b0;
        a_in = a; b_in = b; op_in = op; in_valid = 1'b1;
        for (int i = 0; i < 80 && !done; i++) begin
            if (in_ready) begin
                push_exp(a, b, op);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic wait_result();
        for (int i = 0; i < 40 && !out_valid; i++) tick();
        check("result_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // ---------------- monitor ----------------
    logic prev_valid = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (out_valid && !prev_valid) begin
            check("lat_pending", {31'd0, acc_q.size() != 0}, 32'd1);
            if (acc_q.size() != 0) check("latency", cyc - acc_q.pop_front(), W + 2);
        end
        prev_valid = out_valid;
        if (out_valid && out_ready) begin
            check("res_pending", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_y", {24'd0, y_out}, {24'd0, e[W-1:0]});
                check("sb_c", {31'd0, c_out}, {31'd0, e[W]});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int t1;
        rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
        tick(); tick();
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        check("rst_alu_op",    {29'd0, alu_op},    32'd0);
        check("rst_y_out",     {24'd0, y_out},     32'd0);
        check("rst_c_out",     {31'd0, c_out},     32'd0);
        check("rst_alu_ab",    {30'd0, alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD then SUB back-to-back: latency via monitor, throughput here.
        send(8'd200, 8'd100, OP_ADD);
        check("shift_alu_rst_n", {31'd0, alu_rst_n}, 32'd1);
        check("shift_in_ready",  {31'd0, in_ready},  32'd0);
        wait_result();
        check("add_y", {24'd0, y_out}, 32'd44);
        check("add_c", {31'd0, c_out}, 32'd1);
        t1 = last_acc;
        send(8'd5, 8'd7, OP_SUB);
        check("throughput", last_acc - t1, W + 3);
        wait_result();
        check("sub_y", {24'd0, y_out}, 32'd254);

        send(8'd9, 8'd3, OP_GT);
        wait_result();
        check("gt_y", {24'd0, y_out}, 32'd9);
        check("gt_c", {31'd0, c_out}, 32'd1);
        send(8'h5A, 8'h5A, OP_EQ);
        wait_result();
        check("eq_y", {24'd0, y_out}, 32'h5A);
        check("eq_c", {31'd0, c_out}, 32'd1);
        tick();

        // Back-pressure on XOR with a competing request held off.
        man_ready = 1'b0;
        send(8'hF0, 8'h3C, OP_XOR);
        wait_result();
        a_in = 8'h33; b_in = 8'h55; op_in = OP_AND; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_y",        {24'd0, y_out},     32'hCC);
            check("bp_c",        {31'd0, c_out},     32'd0);
            check("bp_in_ready", {31'd0, in_ready},  32'd0);
            check("bp_valid",    {31'd0, out_valid}, 32'd1);
            tick();
        end
        man_ready = 1'b1;
        tick();
        check("bp_valid_fall", {31'd0, out_valid}, 32'd0);
        check("bp_ready_rise", {31'd0, in_ready},  32'd1);
        if (in_ready) push_exp(8'h33, 8'h55, OP_AND);
        tick();
        in_valid = 1'b0;
        wait_result();
        tick();

        // Reset in the middle of SHIFT discards the word.
        send(8'h12, 8'h34, OP_ADD);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check("midrst_valid",     {31'd0, out_valid}, 32'd0);
        check("midrst_alu_rst_n", {31'd0, alu_rst_n}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd0);
        check("midrst_alu_a",     {31'd0, alu_a},     32'd0);
        exp_q.delete();
        acc_q.delete();
        rst_n = 1'b1;
        tick();
        check("midrst_idle", {31'd0, in_ready}, 32'd1);
        check("midrst_op",   {29'd0, alu_op},   32'd0);
        send(8'hFF, 8'h0F, OP_AND);
        wait_result();
        check("and_y", {24'd0, y_out}, 32'h0F);
        check("and_c", {31'd0, c_out}, 32'd1);
        tick();

        // Input churn during SHIFT must not disturb the latched word.
        send(8'h00, 8'h81, OP_OR);
        for (int i = 0; i < W; i++) begin
            a_in = 8'($urandom); b_in = 8'($urandom); op_in = 3'($urandom);
            check("churn_op", {29'd0, alu_op}, {29'd0, OP_OR});
            tick();
        end
        wait_result();
        check("or_y",  {24'd0, y_out},  32'h81);
        check("or_c",  {31'd0, c_out},  32'd0);
        check("or_op", {29'd0, alu_op}, {29'd0, OP_OR});
        tick();

        // Random operations with random consumer back-pressure.
        rand_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) tick();
        end
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        rand_bp = 1'b0;
        tick(); tick();
        check("drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
